// File: rtl/l2_cache_pkg.sv
// Shared L2 cache definitions: line address type, pending-miss entry layout
// and the default pending-miss queue depth.
package l2_cache_pkg;

    localparam int DEFAULT_PENDING_QUEUE_SIZE = 16;
    localparam int DEFAULT_ADDR_WIDTH         = 26;

    // Storage is sized for the widest supported configuration; instances
    // zero-extend narrower addresses and waiter counts into these fields.
    // ADDR_WIDTH must not exceed MAX_ADDR_WIDTH, WAITER_WIDTH must not
    // exceed MAX_WAITER_WIDTH.
    localparam int MAX_ADDR_WIDTH   = 64;
    localparam int MAX_WAITER_WIDTH = 8;

    typedef logic [MAX_ADDR_WIDTH-1:0]   line_addr_t;
    typedef logic [MAX_WAITER_WIDTH-1:0] waiter_cnt_t;

    typedef struct packed {
        logic        valid;
        line_addr_t  address;
        waiter_cnt_t waiters;
    } pending_entry_t;

endpackage

// File: rtl/pending_miss_priority_encoder.sv
// Lowest-index free-entry finder for the pending-miss table.
// Produces a one-hot grant for the lowest set bit of free_mask.
module pending_miss_priority_encoder #(
    parameter int QUEUE_SIZE = 16
) (
    input  logic [QUEUE_SIZE-1:0] free_mask,
    output logic                  found,
    output logic [QUEUE_SIZE-1:0] grant
);

    // Two's-complement trick isolates the lowest set bit in one adder.
    always_comb begin
        found = |free_mask;
        grant = free_mask & (~free_mask + QUEUE_SIZE'(1));
    end

endmodule

// File: rtl/l2_pending_miss_tracker.sv
// L2 pending-miss tracker: CAM of outstanding system-memory line misses.
// Flags duplicate misses, merges waiters, releases on fill data, and
// provides full/almost-full backpressure plus a sticky overflow flag.
// Optional statistics counters are built when L2_PENDING_MISS_STATS_EN is
// defined.
module l2_pending_miss_tracker
    import l2_cache_pkg::*;
#(
    parameter int QUEUE_SIZE            = DEFAULT_PENDING_QUEUE_SIZE,
    parameter int ADDR_WIDTH            = DEFAULT_ADDR_WIDTH,
    parameter int WAITER_WIDTH          = 3,
    parameter int ALMOST_FULL_THRESHOLD = QUEUE_SIZE - 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rd_pci_valid,
    input  logic [ADDR_WIDTH-1:0]         rd_pci_address,
    input  logic                          rd_cache_hit,
    input  logic                          rd_has_sm_data,
    output logic                          duplicate_request,
    output logic [$clog2(QUEUE_SIZE)-1:0] hit_entry,
    output logic [WAITER_WIDTH-1:0]       release_waiters,
    output logic                          full,
    output logic                          almost_full,
    output logic [$clog2(QUEUE_SIZE):0]   pending_count,
    output logic                          overflow_error
`ifdef L2_PENDING_MISS_STATS_EN
    ,
    output logic [31:0]                   stat_allocs,
    output logic [31:0]                   stat_merges,
    output logic [31:0]                   stat_releases,
    output logic [31:0]                   stat_full_cycles
`endif
);

    localparam int IDX_W = $clog2(QUEUE_SIZE);
    localparam int CNT_W = IDX_W + 1;
    localparam waiter_cnt_t WAITER_MAX = waiter_cnt_t'((1 << WAITER_WIDTH) - 1);

    pending_entry_t entries_q [QUEUE_SIZE];
    pending_entry_t entries_d [QUEUE_SIZE];

    logic [CNT_W-1:0]      count_q, count_d;
    logic                  full_q, full_d;
    logic                  almost_full_q, almost_full_d;
    logic                  overflow_q, overflow_d;

    logic [QUEUE_SIZE-1:0] match_vec;
    logic [QUEUE_SIZE-1:0] free_vec;
    logic [QUEUE_SIZE-1:0] alloc_grant;
    logic                  free_found;
    logic                  match_any;
    logic [IDX_W-1:0]      hit_idx;
    waiter_cnt_t           hit_waiters;
    line_addr_t            lookup_addr;

    logic                  do_release;
    logic                  do_merge;
    logic                  do_alloc_req;
    logic                  do_alloc;

    assign lookup_addr = line_addr_t'(rd_pci_address);

    // Per-entry CAM compare and free flags.
    generate
        for (genvar gi = 0; gi < QUEUE_SIZE; gi++) begin : g_cam
            assign match_vec[gi] = entries_q[gi].valid &&
                                   (entries_q[gi].address == lookup_addr);
            assign free_vec[gi]  = ~entries_q[gi].valid;
        end
    endgenerate

    pending_miss_priority_encoder #(
        .QUEUE_SIZE (QUEUE_SIZE)
    ) u_free_finder (
        .free_mask (free_vec),
        .found     (free_found),
        .grant     (alloc_grant)
    );

    // Encode the (at most one-hot) match vector and mux out its waiter count.
    always_comb begin
        hit_idx     = '0;
        hit_waiters = '0;
        for (int i = 0; i < QUEUE_SIZE; i++) begin
            if (match_vec[i]) begin
                hit_idx     = hit_idx | IDX_W'(i);
                hit_waiters = hit_waiters | entries_q[i].waiters;
            end
        end
    end

    // Request classification and combinational lookup outputs.
    always_comb begin
        match_any         = |match_vec;
        do_release        = rd_pci_valid && match_any && rd_has_sm_data;
        do_merge          = rd_pci_valid && match_any && !rd_has_sm_data && !rd_cache_hit;
        do_alloc_req      = rd_pci_valid && !match_any && !rd_has_sm_data && !rd_cache_hit;
        do_alloc          = do_alloc_req && free_found;
        duplicate_request = rd_pci_valid && match_any;
        hit_entry         = hit_idx;
        release_waiters   = do_release ? hit_waiters[WAITER_WIDTH-1:0] : '0;
    end

    // Next-state for the entry table, occupancy and status flags.
    always_comb begin
        entries_d  = entries_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        for (int i = 0; i < QUEUE_SIZE; i++) begin
            if (do_release && match_vec[i]) begin
                entries_d[i].valid   = 1'b0;
                entries_d[i].waiters = '0;
            end
            if (do_merge && match_vec[i] && (hit_waiters != WAITER_MAX)) begin
                entries_d[i].waiters = hit_waiters + waiter_cnt_t'(1);
            end
            if (do_alloc && alloc_grant[i]) begin
                entries_d[i].valid   = 1'b1;
                entries_d[i].address = lookup_addr;
                entries_d[i].waiters = '0;
            end
        end
        if (do_release) begin
            count_d = count_q - CNT_W'(1);
        end else if (do_alloc) begin
            count_d = count_q + CNT_W'(1);
        end
        if (do_alloc_req && !free_found) begin
            overflow_d = 1'b1;
        end
        full_d        = (count_d == CNT_W'(QUEUE_SIZE));
        almost_full_d = (count_d >= CNT_W'(ALMOST_FULL_THRESHOLD));
    end

    // State registers; stored addresses are left untouched by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < QUEUE_SIZE; i++) begin
                entries_q[i].valid   <= 1'b0;
                entries_q[i].waiters <= '0;
            end
            count_q       <= '0;
            full_q        <= 1'b0;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            entries_q     <= entries_d;
            count_q       <= count_d;
            full_q        <= full_d;
            almost_full_q <= almost_full_d;
            overflow_q    <= overflow_d;
        end
    end

    assign full           = full_q;
    assign almost_full    = almost_full_q;
    assign pending_count  = count_q;
    assign overflow_error = overflow_q;

`ifdef L2_PENDING_MISS_STATS_EN
    logic [31:0] stat_allocs_q, stat_allocs_d;
    logic [31:0] stat_merges_q, stat_merges_d;
    logic [31:0] stat_releases_q, stat_releases_d;
    logic [31:0] stat_full_q, stat_full_d;

    // Saturating event counters.
    always_comb begin
        stat_allocs_d   = stat_allocs_q;
        stat_merges_d   = stat_merges_q;
        stat_releases_d = stat_releases_q;
        stat_full_d     = stat_full_q;
        if (do_alloc && (stat_allocs_q != '1)) begin
            stat_allocs_d = stat_allocs_q + 32'd1;
        end
        if (do_merge && (stat_merges_q != '1)) begin
            stat_merges_d = stat_merges_q + 32'd1;
        end
        if (do_release && (stat_releases_q != '1)) begin
            stat_releases_d = stat_releases_q + 32'd1;
        end
        if (full_q && (stat_full_q != '1)) begin
            stat_full_d = stat_full_q + 32'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_allocs_q   <= '0;
            stat_merges_q   <= '0;
            stat_releases_q <= '0;
            stat_full_q     <= '0;
        end else begin
            stat_allocs_q   <= stat_allocs_d;
            stat_merges_q   <= stat_merges_d;
            stat_releases_q <= stat_releases_d;
            stat_full_q     <= stat_full_d;
        end
    end

    assign stat_allocs      = stat_allocs_q;
    assign stat_merges      = stat_merges_q;
    assign stat_releases    = stat_releases_q;
    assign stat_full_cycles = stat_full_q;
`endif

endmodule

// File: tb/tb_l2_pending_miss_tracker.sv
// Directed testbench for l2_pending_miss_tracker. A second instance with
// WAITER_WIDTH=2 shares the stimulus to check waiter saturation. Stats
// checks are compiled when L2_PENDING_MISS_STATS_EN is defined.
module tb_l2_pending_miss_tracker;

    logic        clk;
    logic        reset;
    logic        rd_pci_valid;
    logic [25:0] rd_pci_address;
    logic        rd_cache_hit;
    logic        rd_has_sm_data;

    logic        duplicate_request;
    logic [3:0]  hit_entry;
    logic [2:0]  release_waiters;
    logic        full;
    logic        almost_full;
    logic [4:0]  pending_count;
    logic        overflow_error;

    logic        dup2;
    logic [3:0]  hit2;
    logic [1:0]  rw2;
    logic        full2, afull2, ovf2;
    logic [4:0]  pend2;

`ifdef L2_PENDING_MISS_STATS_EN
    logic [31:0] stat_allocs, stat_merges, stat_releases, stat_full_cycles;
    logic [31:0] s2_allocs, s2_merges, s2_releases, s2_full;
`endif

    int vectors;
    int miscompares;

    l2_pending_miss_tracker dut (
        .clk               (clk),
        .reset             (reset),
        .rd_pci_valid      (rd_pci_valid),
        .rd_pci_address    (rd_pci_address),
        .rd_cache_hit      (rd_cache_hit),
        .rd_has_sm_data    (rd_has_sm_data),
        .duplicate_request (duplicate_request),
        .hit_entry         (hit_entry),
        .release_waiters   (release_waiters),
        .full              (full),
        .almost_full       (almost_full),
        .pending_count     (pending_count),
        .overflow_error    (overflow_error)
`ifdef L2_PENDING_MISS_STATS_EN
        ,
        .stat_allocs       (stat_allocs),
        .stat_merges       (stat_merges),
        .stat_releases     (stat_releases),
        .stat_full_cycles  (stat_full_cycles)
`endif
    );

    l2_pending_miss_tracker #(.WAITER_WIDTH(2)) dut_w2 (
        .clk               (clk),
        .reset             (reset),
        .rd_pci_valid      (rd_pci_valid),
        .rd_pci_address    (rd_pci_address),
        .rd_cache_hit      (rd_cache_hit),
        .rd_has_sm_data    (rd_has_sm_data),
        .duplicate_request (dup2),
        .hit_entry         (hit2),
        .release_waiters   (rw2),
        .full              (full2),
        .almost_full       (afull2),
        .pending_count     (pend2),
        .overflow_error    (ovf2)
`ifdef L2_PENDING_MISS_STATS_EN
        ,
        .stat_allocs       (s2_allocs),
        .stat_merges       (s2_merges),
        .stat_releases     (s2_releases),
        .stat_full_cycles  (s2_full)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present a request and let combinational outputs settle (one log line).
    task automatic apply(input logic v, input logic [25:0] a, input logic h, input logic s);
        rd_pci_valid   = v;
        rd_pci_address = a;
        rd_cache_hit   = h;
        rd_has_sm_data = s;
        #1;
        $display("txn v=%0b addr=0x%07h hit=%0b sm=%0b -> dup=%0b entry=%0d rw=%0d pend=%0d",
                 v, a, h, s, duplicate_request, hit_entry, release_waiters, pending_count);
    endtask

    // Commit the presented request on the next rising edge, then idle.
    task automatic tick();
        @(posedge clk);
        #1;
        rd_pci_valid   = 1'b0;
        rd_has_sm_data = 1'b0;
        rd_cache_hit   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (pending_count !== 5'd0) begin miscompares++; $display("FAIL reset_pending: got %0d want 0", pending_count); end
        vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %0b want 0", full); end
        vectors++; if (almost_full !== 1'b0) begin miscompares++; $display("FAIL reset_almost_full: got %0b want 0", almost_full); end
        vectors++; if (overflow_error !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %0b want 0", overflow_error); end
        apply(1'b1, 26'h100, 1'b1, 1'b0);
        vectors++; if (duplicate_request !== 1'b0) begin miscompares++; $display("FAIL reset_dup: got %0b want 0", duplicate_request); end
        vectors++; if (release_waiters !== 3'd0) begin miscompares++; $display("FAIL reset_rw: got %0d want 0", release_waiters); end
        tick();
    endtask

    task automatic test_alloc_merge_release();
        do_reset();
        apply(1'b1, 26'h100, 1'b0, 1'b0);
        vectors++; if (duplicate_request !== 1'b0) begin miscompares++; $display("FAIL first_miss_dup: got %0b want 0", duplicate_request); end
        tick();
        vectors++; if (pending_count !== 5'd1) begin miscompares++; $display("FAIL alloc_pending: got %0d want 1", pending_count); end
        // Back-to-back same address: must be seen as duplicate in entry 0.
        apply(1'b1, 26'h100, 1'b0, 1'b0);
        vectors++; if (duplicate_request !== 1'b1) begin miscompares++; $display("FAIL b2b_dup: got %0b want 1", duplicate_request); end
        vectors++; if (hit_entry !== 4'd0) begin miscompares++; $display("FAIL b2b_entry: got %0d want 0", hit_entry); end
        tick();
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, 26'h100, 1'b0, 1'b0);
            tick();
        end
        vectors++; if (pending_count !== 5'd1) begin miscompares++; $display("FAIL merge_pending: got %0d want 1", pending_count); end
        apply(1'b1, 26'h100, 1'b0, 1'b1);
        vectors++; if (release_waiters !== 3'd3) begin miscompares++; $display("FAIL release_waiters: got %0d want 3", release_waiters); end
        tick();
        vectors++; if (pending_count !== 5'd0) begin miscompares++; $display("FAIL release_pending: got %0d want 0", pending_count); end
        apply(1'b1, 26'h100, 1'b0, 1'b0);
        vectors++; if (duplicate_request !== 1'b0) begin miscompares++; $display("FAIL realloc_dup: got %0b want 0", duplicate_request); end
        tick();
        vectors++; if (pending_count !== 5'd1) begin miscompares++; $display("FAIL realloc_pending: got %0d want 1", pending_count); end
        // Hit on a pending line: reported duplicate, no state change.
        apply(1'b1, 26'h100, 1'b1, 1'b0);
        vectors++; if (duplicate_request !== 1'b1) begin miscompares++; $display("FAIL hit_dup: got %0b want 1", duplicate_request); end
        tick();
        // Fresh entry starts at zero waiters.
        apply(1'b1, 26'h100, 1'b0, 1'b1);
        vectors++; if (release_waiters !== 3'd0) begin miscompares++; $display("FAIL realloc_rw: got %0d want 0", release_waiters); end
        tick();
        // Stray fill to an untracked line changes nothing.
        apply(1'b1, 26'h1ab, 1'b0, 1'b1);
        vectors++; if (release_waiters !== 3'd0) begin miscompares++; $display("FAIL stray_rw: got %0d want 0", release_waiters); end
        tick();
        vectors++; if (pending_count !== 5'd0) begin miscompares++; $display("FAIL stray_pending: got %0d want 0", pending_count); end
    endtask

    task automatic test_saturation();
        do_reset();
        apply(1'b1, 26'h200, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, 26'h200, 1'b0, 1'b0);
            tick();
        end
        apply(1'b1, 26'h200, 1'b0, 1'b1);
        vectors++; if (release_waiters !== 3'd5) begin miscompares++; $display("FAIL sat_w3_rw: got %0d want 5", release_waiters); end
        vectors++; if (rw2 !== 2'd3) begin miscompares++; $display("FAIL sat_w2_rw: got %0d want 3", rw2); end
        tick();
        vectors++; if (pend2 !== 5'd0) begin miscompares++; $display("FAIL sat_w2_pending: got %0d want 0", pend2); end
    endtask

    task automatic test_full_overflow();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            apply(1'b1, 26'(32'h1000 + i), 1'b0, 1'b0);
            vectors++; if (duplicate_request !== 1'b0) begin miscompares++; $display("FAIL fill_dup[%0d]: got %0b want 0", i, duplicate_request); end
            tick();
            vectors++; if (pending_count !== 5'(i + 1)) begin miscompares++; $display("FAIL fill_pending[%0d]: got %0d want %0d", i, pending_count, i + 1); end
            vectors++; if (almost_full !== (i + 1 >= 14)) begin miscompares++; $display("FAIL fill_afull[%0d]: got %0b want %0b", i, almost_full, (i + 1 >= 14)); end
            vectors++; if (full !== (i + 1 == 16)) begin miscompares++; $display("FAIL fill_full[%0d]: got %0b want %0b", i, full, (i + 1 == 16)); end
        end
        vectors++; if (overflow_error !== 1'b0) begin miscompares++; $display("FAIL pre_overflow: got %0b want 0", overflow_error); end
        apply(1'b1, 26'h2000, 1'b0, 1'b0);
        tick();
        vectors++; if (overflow_error !== 1'b1) begin miscompares++; $display("FAIL overflow: got %0b want 1", overflow_error); end
        vectors++; if (pending_count !== 5'd16) begin miscompares++; $display("FAIL overflow_pending: got %0d want 16", pending_count); end
        for (int i = 0; i < 16; i++) begin
            apply(1'b1, 26'(32'h1000 + i), 1'b1, 1'b0);
            vectors++; if (duplicate_request !== 1'b1 || hit_entry !== 4'(i)) begin miscompares++; $display("FAIL keep_entry[%0d]: got dup=%0b entry=%0d want dup=1 entry=%0d", i, duplicate_request, hit_entry, i); end
        end
        apply(1'b1, 26'h2000, 1'b1, 1'b0);
        vectors++; if (duplicate_request !== 1'b0) begin miscompares++; $display("FAIL overflow_not_stored: got %0b want 0", duplicate_request); end
        apply(1'b1, 26'h1005, 1'b0, 1'b1);
        tick();
        vectors++; if (full !== 1'b0 || pending_count !== 5'd15) begin miscompares++; $display("FAIL release5: got full=%0b pend=%0d want full=0 pend=15", full, pending_count); end
        vectors++; if (overflow_error !== 1'b1) begin miscompares++; $display("FAIL overflow_sticky: got %0b want 1", overflow_error); end
        apply(1'b1, 26'h3000, 1'b0, 1'b0);
        tick();
        apply(1'b1, 26'h3000, 1'b1, 1'b0);
        vectors++; if (duplicate_request !== 1'b1 || hit_entry !== 4'd5) begin miscompares++; $display("FAIL reuse_slot: got dup=%0b entry=%0d want dup=1 entry=5", duplicate_request, hit_entry); end
        vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL refull: got %0b want 1", full); end
    endtask

    task automatic test_reset_mid();
        // Drain 6 lines from the full table to leave 10 pending.
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, 26'(32'h1000 + i), 1'b0, 1'b1);
            tick();
        end
        apply(1'b1, 26'h3000, 1'b0, 1'b1);
        tick();
        vectors++; if (pending_count !== 5'd10 || almost_full !== 1'b0) begin miscompares++; $display("FAIL mid_pending: got pend=%0d afull=%0b want pend=10 afull=0", pending_count, almost_full); end
        // Reset wins over a concurrent miss.
        reset = 1'b1;
        apply(1'b1, 26'h4000, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        vectors++; if (pending_count !== 5'd0) begin miscompares++; $display("FAIL mid_reset_pending: got %0d want 0", pending_count); end
        vectors++; if (full !== 1'b0 || overflow_error !== 1'b0) begin miscompares++; $display("FAIL mid_reset_flags: got full=%0b ovf=%0b want 0 0", full, overflow_error); end
        apply(1'b1, 26'h1008, 1'b1, 1'b0);
        vectors++; if (duplicate_request !== 1'b0) begin miscompares++; $display("FAIL mid_reset_dup: got %0b want 0", duplicate_request); end
        apply(1'b1, 26'h4000, 1'b1, 1'b0);
        vectors++; if (duplicate_request !== 1'b0) begin miscompares++; $display("FAIL reset_priority_dup: got %0b want 0", duplicate_request); end
        tick();
    endtask

`ifdef L2_PENDING_MISS_STATS_EN
    task automatic test_stats();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            apply(1'b1, 26'(32'h10 * i), 1'b0, 1'b0);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, 26'h10, 1'b0, 1'b0);
            tick();
        end
        apply(1'b1, 26'h20, 1'b0, 1'b1);
        tick();
        vectors++; if (stat_allocs !== 32'd4) begin miscompares++; $display("FAIL stat_allocs: got %0d want 4", stat_allocs); end
        vectors++; if (stat_merges !== 32'd2) begin miscompares++; $display("FAIL stat_merges: got %0d want 2", stat_merges); end
        vectors++; if (stat_releases !== 32'd1) begin miscompares++; $display("FAIL stat_releases: got %0d want 1", stat_releases); end
        vectors++; if (stat_full_cycles !== 32'd0) begin miscompares++; $display("FAIL stat_full_cycles: got %0d want 0", stat_full_cycles); end
    endtask
`endif

    initial begin
        vectors        = 0;
        miscompares    = 0;
        reset          = 1'b1;
        rd_pci_valid   = 1'b0;
        rd_pci_address = '0;
        rd_cache_hit   = 1'b0;
        rd_has_sm_data = 1'b0;
        tick();
        test_reset();
        test_alloc_merge_release();
        test_saturation();
        test_full_overflow();
        test_reset_mid();
`ifdef L2_PENDING_MISS_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/l2_pending_miss_tracker.md
Name: l2_pending_miss_tracker

Overview:
- Parametrised successor to the L2 pending-miss CAM.
- Records outstanding system-memory line misses so a second miss to the same line is flagged as duplicate and does not issue a new memory transaction.
- Sits at the L2 read stage, alongside the tag-check result, ahead of the system memory request queue.
- Adds over the previous generation: parametrised address width, a per-entry merged-waiter count, full/almost-full backpressure, lowest-index allocation, defined same-cycle release bypass, and a sticky overflow flag.

Parameters:
- QUEUE_SIZE, 16: number of CAM entries. Must be ≥2 and ≥ system memory request queue depth + pipeline stages.
- ADDR_WIDTH, 26: line address width.
- WAITER_WIDTH, 3: width of the per-entry merged-request counter (saturating).
- ALMOST_FULL_THRESHOLD, QUEUE_SIZE-2: pending count at which almost_full asserts.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- rd_pci_valid  in  1  a request is present at the lookup stage this cycle
- rd_pci_address  in  ADDR_WIDTH  line address of the request
- rd_cache_hit  in  1  tag hit for this request
- rd_has_sm_data  in  1  restarted request carrying fill data (releases its entry)
- duplicate_request  out  1  combinational: a valid entry matches rd_pci_address after bypass
- hit_entry  out  $clog2(QUEUE_SIZE)  combinational: index of the matching entry, 0 if none
- release_waiters  out  WAITER_WIDTH  combinational: waiter count of the matched entry when a release occurs, else 0
- full  out  1  registered: all entries valid
- almost_full  out  1  registered: pending_count ≥ ALMOST_FULL_THRESHOLD
- pending_count  out  $clog2(QUEUE_SIZE)+1  registered: number of valid entries
- overflow_error  out  1  registered, sticky: an allocation was needed while full

Behaviour:
- Reset: all entry_valid=0, waiter counts=0, pending_count=0, full=0, almost_full=0, overflow_error=0.
- Stored addresses are don't-care at reset.
- Lookup (combinational): compare rd_pci_address against all valid entries.
  - At most one entry can match (invariant); hit_entry is that index.
  - Outputs are meaningful only when rd_pci_valid=1; when it is 0, duplicate_request=0.
- Actions at posedge when rd_pci_valid and not reset:
  - Release: match && rd_has_sm_data → clear entry_valid and waiter count; pending_count-1; release_waiters shows the count during that cycle.
  - Merge: match && !rd_has_sm_data && !rd_cache_hit → waiter count +1, saturating at 2^WAITER_WIDTH-1. No allocation.
  - Allocate: !match && !rd_cache_hit && !rd_has_sm_data → write the lowest-index invalid entry with the address, valid=1, waiters=0; pending_count+1.
  - Allocate while full: no write, overflow_error←1, state otherwise unchanged.
  - Match && rd_cache_hit && !rd_has_sm_data: no state change; duplicate_request still reported.
  - !match && rd_has_sm_data: no state change (stray fill).
- Latency: new entries are visible to a lookup on the next cycle. A same-address request back-to-back with its allocation reports duplicate_request=1.
- Only one request per cycle, so release and allocate never coincide.
- full and almost_full are derived from the next-state count, registered, and valid from the cycle after the change.
- Reset asserted mid-operation discards all entries in one cycle and takes priority over rd_pci_valid.

Optional Feature:
- Macro L2_PENDING_MISS_STATS_EN.
- With it defined: 32-bit saturating counters stat_allocs, stat_merges, stat_releases, stat_full_cycles (cycles with full=1) are exposed as extra output ports; reset clears them to 0.
- Without it: neither the ports nor the counters exist, and the rest of the behaviour is identical.

Decomposition:
- Shared package l2_cache_pkg holds:
  - a typedef for the line address (ADDR_WIDTH)
  - the pending-entry struct {valid, address, waiters}
  - constant DEFAULT_PENDING_QUEUE_SIZE
- Sub-module: pending_miss_priority_encoder (lowest-index free-entry finder, parametrised by QUEUE_SIZE). The CAM compare stays inline.

Test Plan:
- Reset, then miss to 0x100 (cache_hit=0) → cycle 0 duplicate_request=0; next cycle pending_count=1, entry 0 valid. A second miss to 0x100 → duplicate_request=1, hit_entry=0.
- Three more misses to 0x100 → waiter count 3. A fill (has_sm_data=1) at 0x100 → release_waiters=3, pending_count=0 next cycle, then a miss to 0x100 allocates again.
- WAITER_WIDTH=2 with 5 merges → waiter count saturates at 3; release_waiters=3.
- Fill QUEUE_SIZE distinct misses → full=1 the cycle after the last. One more distinct miss → overflow_error=1 (sticky), no entry overwritten. Release entry 5, then a new miss → it lands in entry 5.
- almost_full rises when pending_count reaches 14 (default). Reset asserted with 10 entries pending → next cycle pending_count=0, full=0, overflow_error=0, and a prior address no longer reports duplicate.
- With L2_PENDING_MISS_STATS_EN: 4 allocs, 2 merges, 1 release → stat_allocs=4, stat_merges=2, stat_releases=1.
